// File: rtl/imc_output_buffer_pkg.sv
// Shared definitions for the IMC output buffer and its neighbours
// (IMC controller, input-buffer sequencer).
package imc_output_buffer_pkg;

    // Buffer operating mode: collect words, or hand them downstream.
    typedef enum logic {
        OB_FILL  = 1'b0,
        OB_DRAIN = 1'b1
    } ob_state_t;

    // Defaults shared across the IMC datapath blocks.
    localparam int OB_DATA_W = 16;
    localparam int OB_DEPTH  = 16;
    localparam int OB_ADDR_W = $clog2(OB_DEPTH);

endpackage

// File: rtl/ob_ram.sv
// DEPTH x DATA_W register array: one write port, one registered read port.
// The read register is cleared by reset; the storage itself is not.
module ob_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read: output changes only when a new head word is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imc_output_buffer.sv
// IMC output buffer: captures one CLSA result word per rising edge of wr_en,
// then drains the buffered words downstream over valid/ready while holding
// the IMC controller off with ob_stall.
//
// Handshake: rd_valid/rd_data/rd_last are registered. A word transfers on a
// cycle where rd_valid & rd_ready are both high; while rd_valid is high and
// rd_ready is low, rd_valid, rd_data and rd_last hold steady.
module imc_output_buffer
    import imc_output_buffer_pkg::*;
#(
    parameter int DATA_W = OB_DATA_W,
    parameter int DEPTH  = OB_DEPTH,
    parameter int ADDR_W = OB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sa_out,
    input  logic              wr_en,
    input  logic              flush,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              ob_stall,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

    ob_state_t         state;
    ob_state_t         state_next;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_addr;

    logic              wr_stb;
    logic              wr_accept;
    logic              wr_drop;
    logic              pop;
    logic              load;
    logic [ADDR_W:0]   remain;
    logic [ADDR_W:0]   count_next;

    // Datapath control: edge detect, accept/drop, pop and head reload.
    always_comb begin
        wr_stb     = wr_en & ~wr_en_q;
        wr_accept  = wr_stb && (state == OB_FILL) && !full;
        wr_drop    = wr_stb && !wr_accept;
        pop        = rd_valid && rd_ready;
        // Entries left once this cycle's pop (if any) completes.
        remain     = pop ? (count - ONE_CNT) : count;
        count_next = wr_accept ? (remain + ONE_CNT) : remain;
        // Load a new head word when the output register is empty or being consumed.
        load       = (state == OB_DRAIN) && (remain != '0) && (!rd_valid || pop);
        rd_addr    = pop ? (rd_ptr + 1'b1) : rd_ptr;
    end

    // Next-state logic for the FILL/DRAIN controller.
    always_comb begin
        state_next = state;
        case (state)
            OB_FILL: begin
                if (full || (flush && ((count != '0) || wr_accept))) begin
                    state_next = OB_DRAIN;
                end
            end
            OB_DRAIN: begin
                if (pop && (remain == '0)) begin
                    state_next = OB_FILL;
                end
            end
            default: state_next = OB_FILL;
        endcase
    end

    // State, pointers, occupancy flags and output handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OB_FILL;
            wr_en_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            state   <= state_next;
            wr_en_q <= wr_en;
            count   <= count_next;
            full    <= (count_next == FULL_CNT);
            empty   <= (count_next == '0);
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end
            if (load) begin
                rd_valid <= 1'b1;
                rd_last  <= (remain == ONE_CNT);
            end else if (pop) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

    assign ob_stall = (state == OB_DRAIN);

    ob_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ob_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (sa_out),
        .rd_en   (load),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_imc_output_buffer.sv
// Bench for imc_output_buffer: scenario tasks against a queue-based model.
module tb_imc_output_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] sa_out = '0;
    logic              wr_en = 1'b0;
    logic              flush = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              ob_stall;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: words held, whether the buffer is draining, sticky overflow.
    logic [DATA_W-1:0] exp_q[$];
    bit                model_drain = 1'b0;
    bit                model_ovf = 1'b0;

    imc_output_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .sa_out   (sa_out),
        .wr_en    (wr_en),
        .flush    (flush),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .ob_stall (ob_stall),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One rising edge of wr_en held for 'hold' cycles, optionally with flush on the strobe cycle.
    task automatic do_write(input logic [DATA_W-1:0] word, input int hold, input bit with_flush);
        sa_out = word;
        wr_en  = 1'b1;
        flush  = with_flush;
        tick();
        flush  = 1'b0;
        if (!model_drain && exp_q.size() < DEPTH) begin
            exp_q.push_back(word);
            if (exp_q.size() == DEPTH || with_flush) model_drain = 1'b1;
        end else begin
            model_ovf = 1'b1;
        end
        vectors++;
        if (count !== exp_q.size() || full !== (exp_q.size() == DEPTH) || overflow !== model_ovf) begin
            miscompares++;
            $display("FAIL write_flags: count=%0d full=%b ovf=%b expected count=%0d full=%b ovf=%b",
                     count, full, overflow, exp_q.size(), exp_q.size() == DEPTH, model_ovf);
        end
        for (int i = 1; i < hold; i++) tick();
        wr_en = 1'b0;
        tick();
    endtask

    task automatic do_flush;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (!model_drain && exp_q.size() > 0) model_drain = 1'b1;
    endtask

    // Consume words. mode 0: ready always high, 1: pattern 1,0,0,1, 2: random.
    task automatic drain(input int mode, input int max_pops, output int cycles);
        int  pops = 0;
        bit  prev_hold = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        logic [DATA_W-1:0] exp_word;
        int  pat [4] = '{1, 0, 0, 1};
        cycles = 0;
        while (pops < max_pops && exp_q.size() > 0 && cycles < 300) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = pat[cycles % 4] != 0;
                default: rd_ready = $urandom_range(0, 1) != 0;
            endcase
            vectors++;
            if (count !== exp_q.size()) begin
                miscompares++;
                $display("FAIL drain_count: count=%0d expected %0d", count, exp_q.size());
            end
            if (prev_hold) begin
                vectors++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL hold_stable: valid=%b data=%h expected valid=1 data=%h",
                             rd_valid, rd_data, prev_data);
                end
            end
            if (rd_valid === 1'b1) begin
                vectors++;
                if (ob_stall !== 1'b1) begin
                    miscompares++;
                    $display("FAIL drain_stall: ob_stall=%b expected 1", ob_stall);
                end
            end
            if (rd_valid === 1'b1 && rd_ready) begin
                exp_word = exp_q.pop_front();
                pops++;
                vectors++;
                if (rd_data !== exp_word || rd_last !== (exp_q.size() == 0)) begin
                    miscompares++;
                    $display("FAIL pop_data: data=%h last=%b expected data=%h last=%b",
                             rd_data, rd_last, exp_word, exp_q.size() == 0);
                end
            end
            prev_hold = (rd_valid === 1'b1) && !rd_ready;
            prev_data = rd_data;
            tick();
            cycles++;
        end
        rd_ready = 1'b0;
        if (cycles >= 300) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d words left after %0d cycles, expected 0", exp_q.size(), cycles);
        end
        if (exp_q.size() == 0) begin
            model_drain = 1'b0;
            vectors++;
            if (rd_valid !== 1'b0 || ob_stall !== 1'b0 || empty !== 1'b1 || count !== 0) begin
                miscompares++;
                $display("FAIL drain_end: valid=%b stall=%b empty=%b count=%0d expected 0 0 1 0",
                         rd_valid, ob_stall, empty, count);
            end
        end
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (count !== 0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 ||
            rd_last !== 1'b0 || ob_stall !== 1'b0 || overflow !== model_ovf) begin
            miscompares++;
            $display("FAIL %s: count=%0d empty=%b full=%b valid=%b last=%b stall=%b ovf=%b expected idle ovf=%b",
                     name, count, empty, full, rd_valid, rd_last, ob_stall, overflow, model_ovf);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        model_ovf = 1'b0;
        check_idle("reset_state");
        vectors++;
        if (rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: rd_data=%h expected 0000", rd_data);
        end
    endtask

    task automatic test_level_write;
        int cyc;
        do_write(16'hA5A5, 5, 1'b0);
        vectors++;
        if (count !== 1 || ob_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL level_write: count=%0d stall=%b expected 1 0", count, ob_stall);
        end
        do_flush();
        drain(0, DEPTH, cyc);
    endtask

    task automatic test_full;
        int cyc;
        for (int i = 1; i < DEPTH; i++) do_write(DATA_W'(i), 1, 1'b0);
        sa_out = DATA_W'(DEPTH);
        wr_en  = 1'b1;
        tick();
        exp_q.push_back(DATA_W'(DEPTH));
        model_drain = 1'b1;
        vectors++;
        if (full !== 1'b1 || count !== DEPTH || ob_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL full_flag: full=%b count=%0d stall=%b expected 1 16 0", full, count, ob_stall);
        end
        wr_en = 1'b0;
        tick();
        vectors++;
        if (ob_stall !== 1'b1 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_entry: stall=%b valid=%b expected 1 0", ob_stall, rd_valid);
        end
        tick();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h0001) begin
            miscompares++;
            $display("FAIL first_valid: valid=%b data=%h expected 1 0001", rd_valid, rd_data);
        end
        drain(0, DEPTH, cyc);
        vectors++;
        if (cyc !== DEPTH) begin
            miscompares++;
            $display("FAIL throughput: %0d cycles expected %0d", cyc, DEPTH);
        end
    endtask

    task automatic test_flush;
        int cyc;
        // Flush with nothing buffered must not start a drain.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (2) tick();
        check_idle("flush_empty");
        for (int i = 0; i < 3; i++) do_write(DATA_W'($urandom), 1, 1'b0);
        do_flush();
        drain(0, DEPTH, cyc);
        // Third write coincides with flush: it is kept and the drain follows.
        for (int i = 0; i < 2; i++) do_write(DATA_W'($urandom), 2, 1'b0);
        do_write(16'hC3C3, 1, 1'b1);
        drain(2, DEPTH, cyc);
    endtask

    task automatic test_overflow;
        int cyc;
        int w;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: overflow=%b expected 0", overflow);
        end
        for (int i = 0; i < DEPTH; i++) do_write(DATA_W'($urandom_range(0, 16'hDEAC)), 1, 1'b0);
        w = 0;
        while (rd_valid !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        for (int i = 0; i < 3; i++) do_write(16'hDEAD, 1, 1'b0);
        vectors++;
        if (overflow !== 1'b1 || count !== DEPTH || rd_data === 16'hDEAD) begin
            miscompares++;
            $display("FAIL overflow: ovf=%b count=%0d data=%h expected 1 16 not-DEAD", overflow, count, rd_data);
        end
        drain(2, DEPTH, cyc);
    endtask

    task automatic test_ready_pattern;
        int cyc;
        for (int i = 0; i < 6; i++) do_write(DATA_W'($urandom), 1, 1'b0);
        do_flush();
        drain(1, DEPTH, cyc);
    endtask

    task automatic test_reset_mid_drain;
        int cyc;
        for (int i = 0; i < 10; i++) do_write(DATA_W'($urandom), 1, 1'b0);
        do_flush();
        drain(0, 3, cyc);
        vectors++;
        if (count !== 7 || ob_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_drain: count=%0d stall=%b expected 7 1", count, ob_stall);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        model_drain = 1'b0;
        model_ovf = 1'b0;
        check_idle("reset_mid_drain");
        do_write(16'h1234, 1, 1'b1);
        drain(0, DEPTH, cyc);
    endtask

    task automatic test_back_to_back;
        int cyc;
        int n;
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) do_write(DATA_W'($urandom), $urandom_range(1, 3), 1'b0);
            if (n < DEPTH) do_flush();
            drain(2, DEPTH, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_level_write();
        test_full();
        test_flush();
        test_ready_pattern();
        test_overflow();
        test_reset_mid_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
